// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_entry_t : one fetch-buffer entry, {pc, instr}
//   INSTR_BYTES   : PC increment between sequential fetches
package ifetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t used as the fetch buffer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (storage clears to 0)
//   flush_i      : drop all entries; wins over push_i and pop_i
//   push_i       : write data_i at the tail (ignored when full without pop)
//   data_i       : entry to write
//   pop_i        : retire the head entry (ignored when empty)
//   head_o       : entry at the head; stale storage when empty
//   count_o      : number of valid entries
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               data_i,
  input  logic                       pop_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // A full FIFO accepts a push only alongside a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (!flush_i && do_push) mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit. Owns the fetch PC, drives it to the combinational
// instruction memory every cycle, and buffers {pc, instr} for decode.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_addr_o       : fetch PC (straight from the PC register)
//   imem_instr_i      : word returned for imem_addr_o in the same cycle
//   redirect_valid_i  : flush the buffer and restart fetch at redirect_pc_i
//   redirect_pc_i     : redirect target; low two bits are dropped
//   out_valid_o       : buffer head is valid
//   out_ready_i       : decode takes the head this cycle
//   out_instr_o       : instruction at the head
//   out_pc_o          : PC of out_instr_o
//   misaligned_o      : sticky, set by any redirect target with pc[1:0] != 0
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        misaligned_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]     pc_q, pc_d;
  logic            misaligned_q, misaligned_d;
  logic            push, pop;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] unused_count;
  fetch_entry_t    wr_entry, head;

  assign pop      = out_valid_o & out_ready_i;
  // Redirect wins: the word at the old PC is discarded, not buffered.
  assign push     = ~redirect_valid_i & (~fifo_full | pop);
  assign wr_entry = '{pc: pc_q, instr: imem_instr_i};

  always_comb begin
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    if (redirect_valid_i) begin
      pc_d         = {redirect_pc_i[31:2], 2'b00};
      misaligned_d = misaligned_q | (|redirect_pc_i[1:0]);
    end else if (push) begin
      pc_d = pc_q + 32'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid_i),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (unused_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign imem_addr_o  = pc_q;
  assign out_valid_o  = ~fifo_empty;
  assign out_instr_o  = head.instr;
  assign out_pc_o     = head.pc;
  assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid, misaligned;

  logic [31:0] imem_addr1, imem_instr1, out_instr1, out_pc1;
  logic        out_valid1, misaligned1;
  logic        out_ready1 = 1'b1;
  logic        redirect_valid1 = 1'b0;
  logic [31:0] redirect_pc1 = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Memory decodes addr[11:2] only; each word carries its index twice.
  function automatic logic [31:0] mem_word(input logic [9:0] widx);
    return {6'h2A, widx, 6'h15, widx};
  endfunction

  assign imem_instr  = mem_word(imem_addr[11:2]);
  assign imem_instr1 = mem_word(imem_addr1[11:2]);

  ifetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr_o      (imem_addr),
    .imem_instr_i     (imem_instr),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_instr_o      (out_instr),
    .out_pc_o         (out_pc),
    .misaligned_o     (misaligned)
  );

  ifetch #(
    .RESET_PC   (32'hFFFF_FFF8),
    .FIFO_DEPTH (2)
  ) dut_wrap (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr_o      (imem_addr1),
    .imem_instr_i     (imem_instr1),
    .redirect_valid_i (redirect_valid1),
    .redirect_pc_i    (redirect_pc1),
    .out_valid_o      (out_valid1),
    .out_ready_i      (out_ready1),
    .out_instr_o      (out_instr1),
    .out_pc_o         (out_pc1),
    .misaligned_o     (misaligned1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every accepted handshake must match the next expected PC.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pc", out_pc, 32'hxxxx_xxxx);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("sb_pc", out_pc, e);
          check("sb_instr", out_instr, mem_word(e[11:2]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    cyc(2);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_misaligned", {31'b0, misaligned}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_addr_wrap", imem_addr1, 32'hFFFF_FFF8);

    // Free-running decode after reset, then stall with ready low.
    exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h08);
    exp_q.push_back(32'h0C); exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    exp_q.push_back(32'h18);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    check("wrap_valid", {31'b0, out_valid1}, 32'h1);
    check("wrap_pc0", out_pc1, 32'hFFFF_FFF8);
    cyc(1);
    check("wrap_pc1", out_pc1, 32'hFFFF_FFFC);
    cyc(1);
    check("wrap_pc2", out_pc1, 32'h0000_0000);
    check("wrap_instr", out_instr1, mem_word(10'd0));
    check("wrap_misaligned", {31'b0, misaligned1}, 32'h0);
    cyc(2);
    out_ready = 1'b0;
    cyc(2);
    check("stall_valid", {31'b0, out_valid}, 32'h1);
    check("stall_addr", imem_addr, 32'h18);
    cyc(3);
    check("stall_addr_hold", imem_addr, 32'h18);
    check("stall_head", out_pc, 32'h10);
    out_ready = 1'b1;
    cyc(3);
    out_ready = 1'b0;

    // Redirect while full.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    cyc(1);
    redirect_valid = 1'b0;
    check("redir_valid", {31'b0, out_valid}, 32'h0);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_misaligned", {31'b0, misaligned}, 32'h0);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    out_ready = 1'b1;
    cyc(1);
    check("redir_head", out_pc, 32'h100);
    cyc(1);

    // Misaligned redirect coincident with a pop.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    cyc(1);
    redirect_valid = 1'b0;
    check("mis_addr", imem_addr, 32'h100);
    check("mis_flag", {31'b0, misaligned}, 32'h1);
    check("mis_valid", {31'b0, out_valid}, 32'h0);
    exp_q.push_back(32'h100);
    cyc(1);

    // Aligned redirect does not clear the sticky flag.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    cyc(1);
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    check("mis_sticky", {31'b0, misaligned}, 32'h1);
    check("mis_aligned_addr", imem_addr, 32'h40);
    cyc(3);
    check("full_valid", {31'b0, out_valid}, 32'h1);
    check("full_addr", imem_addr, 32'h48);
    check("full_head", out_pc, 32'h40);

    // Asynchronous reset mid-stream with a full buffer.
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_pc", out_pc, 32'h0);
    check("mid_rst_misaligned", {31'b0, misaligned}, 32'h0);
    check("mid_rst_addr_wrap", imem_addr1, 32'hFFFF_FFF8);
    cyc(1);
    exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h08);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc(4);
    out_ready = 1'b0;
    cyc(2);
    check("sb_drain", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
